// File: rtl/subcells_iter.sv
// Iterative QARMAv2 S-box layer: LANES forward and LANES inverse cells are time-multiplexed
// over the state by rotating it through the low nibbles, WIDTH/(4*LANES) cycles per block.
module subcells_iter #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned LANES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_inv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int unsigned NIB    = WIDTH / 4;
  localparam int unsigned CYCLES = (LANES == 0) ? 1 : NIB / LANES;
  localparam int unsigned CW     = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam int unsigned LW     = 4 * LANES;

  if ((WIDTH % 4) != 0 || LANES == 0 || LANES > NIB ||
      ((LANES == 0) ? 1 : (NIB % LANES)) != 0) begin : g_param_check
    $error("subcells_iter: WIDTH must be a multiple of 4 and LANES must divide WIDTH/4");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [WIDTH-1:0] data_q;
  logic            mode_q;
  logic [LW-1:0]   lane_out;
  logic [WIDTH-1:0] data_rot;

  function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
    logic [3:0] y;
    unique case (x)
      4'h0: y = 4'h4;  4'h1: y = 4'h7;  4'h2: y = 4'h9;  4'h3: y = 4'hb;
      4'h4: y = 4'hc;  4'h5: y = 4'h6;  4'h6: y = 4'he;  4'h7: y = 4'hf;
      4'h8: y = 4'h0;  4'h9: y = 4'h5;  4'ha: y = 4'h1;  4'hb: y = 4'hd;
      4'hc: y = 4'h8;  4'hd: y = 4'h3;  4'he: y = 4'h2;  4'hf: y = 4'ha;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    logic [3:0] y;
    unique case (x)
      4'h0: y = 4'h8;  4'h1: y = 4'ha;  4'h2: y = 4'he;  4'h3: y = 4'hd;
      4'h4: y = 4'h0;  4'h5: y = 4'h9;  4'h6: y = 4'h5;  4'h7: y = 4'h1;
      4'h8: y = 4'hc;  4'h9: y = 4'h2;  4'ha: y = 4'hf;  4'hb: y = 4'h3;
      4'hc: y = 4'h4;  4'hd: y = 4'hb;  4'he: y = 4'h6;  4'hf: y = 4'h7;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_out[4*l +: 4] = mode_q ? sbox_inv(data_q[4*l +: 4]) : sbox_fwd(data_q[4*l +: 4]);
  end

  // Substituted nibbles re-enter at the top, so after CYCLES steps the order is restored.
  if (LANES == NIB) begin : g_full
    assign data_rot = lane_out;
  end else begin : g_part
    assign data_rot = {lane_out, data_q[WIDTH-1:LW]};
  end

  assign out_data = data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      data_q    <= '0;
      mode_q    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            data_q   <= in_data;
            mode_q   <= in_inv;
            cnt_q    <= '0;
            state_q  <= StRun;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        StRun: begin
          data_q <= data_rot;
          if (cnt_q == CW'(CYCLES - 1)) begin
            cnt_q     <= '0;
            state_q   <= StDone;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state_q   <= StIdle;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
